// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Brief    : Byte-serial instruction fetch feeding the IF/ID boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        JBje_i,
    input  logic [31:0] JBtaraddr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] pc_IFID_o,
    output logic [31:0] inst_IFID_o,
    output logic        valid_IFID_o
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_run;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [31:0] r_shadow;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst_out;
    logic        r_valid_out;

    logic        w_ack;
    logic        w_slot_free;
    logic [31:0] w_word;

    // r_run holds off the first request for one cycle after reset release
    assign mem_req_o   = r_run && (r_state == S_FETCH) && !JBje_i;
    assign mem_addr_o  = r_pc + {30'd0, r_cnt};
    assign w_ack       = mem_req_o && mem_ack_i;
    assign w_slot_free = !r_valid_out || !stall_i;
    assign w_word      = {mem_rdata_i, r_shadow[23:0]};

    assign pc_IFID_o    = r_pc_out;
    assign inst_IFID_o  = r_inst_out;
    assign valid_IFID_o = r_valid_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH;
            r_run       <= 1'b0;
            r_pc        <= RESET_PC;
            r_cnt       <= 2'd0;
            r_shadow    <= 32'd0;
            r_pc_out    <= 32'd0;
            r_inst_out  <= NOP_INST;
            r_valid_out <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (JBje_i) begin
                r_pc        <= JBtaraddr_i;
                r_cnt       <= 2'd0;
                r_state     <= S_FETCH;
                r_shadow    <= 32'd0;
                r_valid_out <= 1'b0;
                r_inst_out  <= NOP_INST;
            end else begin
                // Consumed slot empties unless a new word overrides below
                if (!stall_i) begin
                    r_valid_out <= 1'b0;
                    r_inst_out  <= NOP_INST;
                end
                case (r_state)
                    S_FETCH: begin
                        if (w_ack) begin
                            r_shadow[{r_cnt, 3'b000} +: 8] <= mem_rdata_i;
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                if (w_slot_free) begin
                                    r_valid_out <= 1'b1;
                                    r_pc_out    <= r_pc;
                                    r_inst_out  <= w_word;
                                    r_pc        <= r_pc + 32'd4;
                                end else begin
                                    r_state <= S_FULL;
                                end
                            end
                        end
                    end
                    S_FULL: begin
                        if (!stall_i) begin
                            r_valid_out <= 1'b1;
                            r_pc_out    <= r_pc;
                            r_inst_out  <= r_shadow;
                            r_pc        <= r_pc + 32'd4;
                            r_cnt       <= 2'd0;
                            r_state     <= S_FETCH;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Self-checking bench for if_fetch with a byte-wide memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        JBje_i;
    logic [31:0] JBtaraddr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] pc_IFID_o;
    logic [31:0] inst_IFID_o;
    logic        valid_IFID_o;

    int          checks = 0;
    int          errors = 0;
    logic        slow_mem = 1'b0;
    int unsigned cyc = 0;

    if_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .JBje_i       (JBje_i),
        .JBtaraddr_i  (JBtaraddr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .pc_IFID_o    (pc_IFID_o),
        .inst_IFID_o  (inst_IFID_o),
        .valid_IFID_o (valid_IFID_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mb(input logic [31:0] a);
        case (a)
            32'd0:   mb = 8'h13;
            32'd1:   mb = 8'h05;
            32'd2:   mb = 8'h10;
            32'd3:   mb = 8'h00;
            default: mb = a[7:0] + 8'h40;
        endcase
    endfunction

    function automatic logic [31:0] ew(input logic [31:0] p);
        ew = {mb(p + 32'd3), mb(p + 32'd2), mb(p + 32'd1), mb(p)};
    endfunction

    // Zero-wait mode holds ack high permanently; the DUT must qualify it with req
    assign mem_ack_i   = slow_mem ? (mem_req_o && (cyc % 3 == 0)) : 1'b1;
    assign mem_rdata_i = mb(mem_addr_o);

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        stall_i     = 1'b0;
        JBje_i      = 1'b0;
        JBtaraddr_i = 32'd0;
        slow_mem    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_IFID_o}, 32'd0);
        chk("rst_inst",  inst_IFID_o, C_NOP);
        chk("rst_pc",    pc_IFID_o, 32'd0);
        chk("rst_addr",  mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int max_cyc, output int used);
        used = 0;
        while (!valid_IFID_o && used < max_cyc) begin
            @(negedge clk);
            #1;
            used++;
        end
        checks++;
        if (!valid_IFID_o) begin
            errors++;
            $display("FAIL wait_valid: valid still %b after %0d cycles", valid_IFID_o, max_cyc);
        end
    endtask

    vec_t vecs[10];
    int   n;
    int   got;

    initial begin
        rst = 1'b0;
        stall_i = 1'b0;
        JBje_i = 1'b0;
        JBtaraddr_i = 32'd0;

        vecs[0] = '{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, C_NOP};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0, C_NOP};
        vecs[2] = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0, C_NOP};
        vecs[3] = '{1'b0, 1'b1, 32'd2, 1'b0, 32'd0, C_NOP};
        vecs[4] = '{1'b0, 1'b1, 32'd3, 1'b0, 32'd0, C_NOP};
        vecs[5] = '{1'b0, 1'b1, 32'd4, 1'b1, 32'd0, 32'h0010_0513};
        vecs[6] = '{1'b0, 1'b1, 32'd5, 1'b0, 32'd0, C_NOP};
        vecs[7] = '{1'b0, 1'b1, 32'd6, 1'b0, 32'd0, C_NOP};
        vecs[8] = '{1'b0, 1'b1, 32'd7, 1'b0, 32'd0, C_NOP};
        vecs[9] = '{1'b0, 1'b1, 32'd8, 1'b1, 32'd4, 32'h4746_4544};

        // Zero-wait fetch from reset release, one row per cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            stall_i = vecs[k].stall;
            chk($sformatf("tbl%0d_req", k),   {31'd0, mem_req_o}, {31'd0, vecs[k].req});
            chk($sformatf("tbl%0d_addr", k),  mem_addr_o, vecs[k].addr);
            chk($sformatf("tbl%0d_valid", k), {31'd0, valid_IFID_o}, {31'd0, vecs[k].valid});
            chk($sformatf("tbl%0d_pc", k),    pc_IFID_o, vecs[k].pc);
            chk($sformatf("tbl%0d_inst", k),  inst_IFID_o, vecs[k].inst);
        end

        // Slow memory: ack every third cycle
        do_reset();
        slow_mem = 1'b1;
        got = 0;
        for (int c = 0; c < 150 && got < 3; c++) begin
            @(negedge clk);
            #1;
            if (valid_IFID_o) begin
                chk("slow_pc",   pc_IFID_o, 32'(4 * got));
                chk("slow_inst", inst_IFID_o, ew(32'(4 * got)));
                @(negedge clk);
                #1;
                chk("slow_pulse", {31'd0, valid_IFID_o}, 32'd0);
                got++;
            end
        end
        chk("slow_count", 32'(got), 32'd3);
        slow_mem = 1'b0;

        // Stall holds the output; second word parks with no requests
        do_reset();
        wait_valid(20, n);
        stall_i = 1'b1;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", {31'd0, valid_IFID_o}, 32'd1);
            chk("stall_pc",    pc_IFID_o, 32'd0);
            chk("stall_inst",  inst_IFID_o, 32'h0010_0513);
        end
        chk("full_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        stall_i = 1'b0;
        #1;
        chk("unstall_pc_hold", pc_IFID_o, 32'd0);
        @(negedge clk);
        #1;
        chk("unstall_valid", {31'd0, valid_IFID_o}, 32'd1);
        chk("unstall_pc",    pc_IFID_o, 32'd4);
        chk("unstall_inst",  inst_IFID_o, ew(32'd4));
        chk("unstall_addr",  mem_addr_o, 32'd8);
        chk("unstall_req",   {31'd0, mem_req_o}, 32'd1);

        // Redirect at byte 2 with ack high in the same cycle
        do_reset();
        wait_valid(20, n);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("jb_pre_addr", mem_addr_o, 32'd6);
        JBje_i      = 1'b1;
        JBtaraddr_i = 32'h0000_0100;
        #1;
        chk("jb_req_gate", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        JBje_i = 1'b0;
        #1;
        chk("jb_valid", {31'd0, valid_IFID_o}, 32'd0);
        chk("jb_inst",  inst_IFID_o, C_NOP);
        chk("jb_addr0", mem_addr_o, 32'h100);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("jb_addr", mem_addr_o, 32'h100 + 32'(i));
        end
        wait_valid(10, n);
        chk("jb_pc",   pc_IFID_o, 32'h100);
        chk("jb_word", inst_IFID_o, ew(32'h100));

        // Redirect beats stall while the output is valid
        do_reset();
        wait_valid(20, n);
        stall_i     = 1'b1;
        JBje_i      = 1'b1;
        JBtaraddr_i = 32'h0000_0200;
        @(negedge clk);
        JBje_i  = 1'b0;
        stall_i = 1'b0;
        #1;
        chk("jbst_valid", {31'd0, valid_IFID_o}, 32'd0);
        chk("jbst_inst",  inst_IFID_o, C_NOP);
        chk("jbst_addr",  mem_addr_o, 32'h200);
        wait_valid(10, n);
        chk("jbst_pc",   pc_IFID_o, 32'h200);
        chk("jbst_word", inst_IFID_o, ew(32'h200));

        // Address and PC wrap at the top of the address space
        do_reset();
        wait_valid(20, n);
        JBje_i      = 1'b1;
        JBtaraddr_i = 32'hFFFF_FFFE;
        @(negedge clk);
        JBje_i = 1'b0;
        #1;
        chk("wrap_addr0", mem_addr_o, 32'hFFFF_FFFE);
        @(negedge clk);
        #1;
        chk("wrap_addr1", mem_addr_o, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("wrap_addr2", mem_addr_o, 32'h0000_0000);
        @(negedge clk);
        #1;
        chk("wrap_addr3", mem_addr_o, 32'h0000_0001);
        wait_valid(10, n);
        chk("wrap_pc",   pc_IFID_o, 32'hFFFF_FFFE);
        chk("wrap_word", inst_IFID_o, ew(32'hFFFF_FFFE));
        chk("wrap_next", mem_addr_o, 32'h0000_0002);

        // Asynchronous reset mid-fetch, then clean restart
        do_reset();
        wait_valid(20, n);
        stall_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ar_pre_addr",  mem_addr_o, 32'd6);
        chk("ar_pre_valid", {31'd0, valid_IFID_o}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req",   {31'd0, mem_req_o}, 32'd0);
        chk("ar_valid", {31'd0, valid_IFID_o}, 32'd0);
        chk("ar_inst",  inst_IFID_o, C_NOP);
        chk("ar_addr",  mem_addr_o, 32'd0);
        @(negedge clk);
        stall_i = 1'b0;
        rst     = 1'b1;
        #1;
        wait_valid(20, n);
        chk("ar_latency", 32'(n), 32'd5);
        chk("ar_pc",      pc_IFID_o, 32'd0);
        chk("ar_word",    inst_IFID_o, 32'h0010_0513);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the PC and fetches each 32-bit instruction as four sequential byte reads over the byte-wide memory port, assembling them little-endian.
- Presents {pc, inst, valid} to the IF/ID boundary.
- Obeys stall requests from the staller and redirect requests (jump/branch-taken, target) from decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word driven while the output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  staller hold request for IF. While 1, the presented instruction must not advance.
- JBje_i  in  1  redirect enable from decode; single-cycle pulse.
- JBtaraddr_i  in  32  redirect target PC, valid when JBje_i=1.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address of the current request.
- mem_ack_i  in  1  read accepted and data valid this cycle; meaningful only when mem_req_o=1.
- mem_rdata_i  in  8  read byte, valid with mem_ack_i.
- pc_IFID_o  out  32  PC of the presented instruction.
- inst_IFID_o  out  32  presented instruction.
- valid_IFID_o  out  1  presented instruction is valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc <= RESET_PC; byte counter <= 0; state <= FETCH.
  - mem_req_o=0, mem_addr_o=RESET_PC.
  - valid_IFID_o=0, pc_IFID_o=0, inst_IFID_o=NOP_INST.
  - Releasing rst mid-fetch restarts cleanly at RESET_PC.
- State FETCH:
  - mem_req_o=1, mem_addr_o=pc+cnt, where cnt is the 2-bit byte counter.
  - On each ack: byte cnt of the shadow word <= mem_rdata_i (byte 0 -> bits[7:0]); cnt <= cnt+1.
  - On the ack with cnt=3, the word is complete:
    - If the output slot is free (valid_IFID_o=0, or stall_i=0 this cycle): load the output next edge with valid=1, pc_IFID_o=pc, inst=assembled word; then pc <= pc+4, cnt <= 0, stay in FETCH.
    - Otherwise go to FULL, holding the completed word and its PC in the shadow registers.
- State FULL:
  - mem_req_o=0.
  - When stall_i=0: shadow -> output (valid=1), pc <= pc+4, cnt <= 0, go to FETCH.
- Output slot:
  - With stall_i=1: all three outputs hold.
  - With stall_i=0 and no new word: valid_IFID_o <= 0 and inst <= NOP_INST after the current instruction is consumed; pc_IFID_o holds.
- Latency: with zero-wait memory (ack in the same cycle as req), the first valid_IFID_o appears on the 5th rising edge after rst deasserts. Throughput is 1 instruction per 4 cycles.
- Redirect (JBje_i=1):
  - Highest priority; overrides stall_i and any ack arriving in the same cycle (that byte is discarded).
  - Next edge: pc <= JBtaraddr_i; cnt <= 0; state <= FETCH; shadow cleared; valid_IFID_o <= 0, inst <= NOP_INST.
  - mem_req_o is driven 0 combinationally in the JBje_i cycle so no stale byte is accepted.
  - Target bits [1:0] are used as-is; no alignment trap.
- Stall alone never drops an in-flight byte. FETCH keeps collecting bytes until the word completes, then waits in FULL.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 -> 0. mem_addr_o also wraps (pc=32'hFFFF_FFFE, cnt=3 -> 32'h0000_0001).
- mem_req_o is never asserted in FULL or during reset.

Test Plan:
- Reset release, zero-wait memory returning bytes 13,05,10,00 at 0..3 -> on edge 5: valid=1, pc=0, inst=32'h0010_0513; mem_addr_o then steps 4,5,6,7.
- Memory acks only every 3rd cycle -> inst still assembled correctly; valid pulses once per word; pc_IFID_o sequence 0,4,8.
- stall_i=1 held 10 cycles after the first word -> outputs frozen at pc=0; second word parks in FULL with mem_req_o=0. Release stall -> pc_IFID_o=4 on the next edge.
- JBje_i pulse with target 32'h0000_0100 during byte cnt=2 of a fetch, ack in the same cycle -> that byte ignored; valid=0 next edge; subsequent mem_addr_o=0x100..0x103; next valid word has pc=0x100.
- JBje_i and stall_i both 1 with the output valid -> redirect wins: valid drops, pc reloads.
- Assert rst=0 asynchronously mid-FETCH (cnt=2) -> mem_req_o and valid_IFID_o drop immediately; after release, fetch restarts at RESET_PC.
